i2c_req_arbiter: RTL and testbench
==================================

# i2c_req_arbiter

Round-robin arbiter and sequencer that shares one `i2c_master` between `NREQ` independent requesters. It accepts per-requester transaction requests (7-bit address, R/W op, write byte) and grants one at a time. It drives the master's `newd/addr/op/din` handshake, waits for `done`, and returns read data and error status to the winning requester. A watchdog aborts a transaction that never completes by pulsing the master's reset.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 16384: max cycles from grant to master `done` before abort; counter width `$clog2(TIMEOUT+1)`.
- `clk`  in  1  system clock (same clock as `i2c_master`).
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  per-requester request, level.
- `req_addr`  in  7*NREQ  slave address; requester i uses bits [7i+6:7i].
- `req_op`  in  NREQ  1 = read, 0 = write.
- `req_din`  in  8*NREQ  write byte; requester i uses bits [8i+7:8i].
- `gnt`  out  NREQ  one-hot, one-cycle pulse: request accepted, fields captured.
- `rsp_valid`  out  NREQ  one-hot, one-cycle pulse: transaction finished.
- `rsp_data`  out  8  read byte, valid with `rsp_valid`, held until next response.
- `rsp_err`  out  1  slave NACK or timeout, valid with `rsp_valid`, held.
- `rsp_timeout`  out  1  abort by watchdog, valid with `rsp_valid`, held.
- `arb_busy`  out  1  high from grant through response cycle.
- `m_newd`, `m_addr[6:0]`, `m_op`, `m_din[7:0]`  out  drive master `newd/addr/op/din`.
- `m_busy`, `m_done`, `m_ack_err`, `m_dout[7:0]`  in  from master.
- `m_rst`  out  1  master reset: `rst` OR one-cycle registered abort pulse.

## Operation
- States: IDLE, ISSUE, WAIT_DONE. Round-robin pointer `ptr` is reset to 0.
- IDLE: if `req != 0`, search for the first set bit from `ptr` upward, wrapping modulo NREQ. The result is `win`.
  - Latch `req_addr/op/din` of `win` into `m_addr/m_op/m_din`.
  - Pulse `gnt[win]`, set `m_newd=1` and `arb_busy=1`, clear the timer, go to ISSUE.
  - `req` bits are ignored outside IDLE.
- ISSUE: hold `m_newd=1` until `m_busy=1` is sampled. Then clear `m_newd` on the next edge and go to WAIT_DONE.
- WAIT_DONE: on `m_done=1`:
  - Capture `rsp_data=m_dout`, `rsp_err=m_ack_err`, `rsp_timeout=0`.
  - Pulse `rsp_valid[win]`, set `ptr=(win+1) mod NREQ`, go to IDLE.
- Watchdog:
  - The timer increments every cycle in ISSUE/WAIT_DONE.
  - If timer == TIMEOUT-1 and `m_done=0`, it fires a one-cycle `m_rst` pulse and clears `m_newd`.
  - It also sets `rsp_err=1`, `rsp_timeout=1`, `rsp_data=0`, pulses `rsp_valid[win]`, advances `ptr`, and goes to IDLE.
- `m_addr/m_op/m_din` hold their captured values until the next grant.
- Requester contract: hold `req` and fields stable until `gnt`. A `req` still high after `gnt` is a new transaction.

## Timing
- Reset values: `gnt=0`, `rsp_valid=0`, `rsp_data=0`, `rsp_err=0`, `rsp_timeout=0`, `arb_busy=0`, `m_newd=0`, `m_addr=0`, `m_op=0`, `m_din=0`, `m_rst=1` (follows `rst`), state IDLE, `ptr=0`.
- Cycle counting in this section:
  - T = first edge on which IDLE samples `req != 0`.
  - "At T+n" = the registered output value after edge T+n.
- Grant: `gnt` and `m_newd` are high at T+1.
- Master handshake:
  - The master samples `newd` at T+2, so `m_busy` is high at T+2.
  - The arbiter samples `m_busy`=1 at T+3, so `m_newd=0` at T+3.
  - `newd` is never high when the master returns to idle.
- Response: `m_done` sampled high at edge D gives `rsp_valid`, `rsp_data` and `rsp_err` at D+1. `arb_busy` drops at D+2.
- Back-to-back: the state is IDLE at D+1, so a pending request is granted at D+2. Minimum arbiter overhead is 4 cycles per transaction beyond the master's own duration.
- Timeout: abort fires TIMEOUT cycles after the `gnt` cycle. `m_rst` and `rsp_valid` are high in the same cycle.
- Simultaneous `m_done` and timeout: `m_done` wins, no abort.
- `rst` in any state: all outputs return to reset values on the next edge, no `rsp_valid` is issued, and the in-flight transaction is dropped.
- NREQ=1 wrap: `ptr` stays 0.

## Test plan
- Write, single requester: `req=0001`, addr 0x50, op 0, din 0xA5, slave ACKs.
  - Response: `gnt[0]` for one cycle at T+1.
  - `m_newd` high exactly 2 cycles, master writes `0xA0` then `0xA5`.
  - `rsp_valid[0]` with `rsp_err=0`, `rsp_timeout=0`.
- Fairness: `req=1011` held high continuously after reset.
  - Grant order 0,1,3,0,1,3.
  - Exactly one `gnt` per transaction, never overlapping `arb_busy`.
- Read: requester 2, addr 0x51, op 1, slave model returns 0x3C.
  - `rsp_valid[2]` with `rsp_data=0x3C`, `rsp_err=0`.
- NACK: requester 1 targets an absent address 0x12, `m_ack_err=1` with `m_done`.
  - `rsp_valid[1]`, `rsp_err=1`, `rsp_timeout=0`, `ptr` advances to 2.
- Timeout: `TIMEOUT=64`, master stub never asserts `m_done`, requester 3 is active.
  - `m_rst` and `rsp_valid[3]` pulse together 64 cycles after `gnt[3]`.
  - `rsp_err=1`, `rsp_timeout=1`, `rsp_data=0`, state IDLE.
- Reset mid-transaction: assert `rst` for one cycle while in WAIT_DONE with requester 2 active.
  - All outputs zero on the next cycle, no `rsp_valid`.
  - With `req=0110` held, the next grant goes to requester 1 (`ptr` is 0 after reset).

Source files
------------

// File: rtl/i2c_req_arbiter_if.sv
// i2c_req_arbiter_if: arbiter bus; slave = arbiter view (req/req_* and m_busy/m_done/m_ack_err/m_dout in; gnt/rsp_*/arb_busy and m_newd/m_addr/m_op/m_din/m_rst out), master = requester/master-side view
interface i2c_req_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [7*NREQ-1:0] req_addr;
  logic [NREQ-1:0]   req_op;
  logic [8*NREQ-1:0] req_din;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_valid;
  logic [7:0]        rsp_data;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              arb_busy;
  logic              m_newd;
  logic [6:0]        m_addr;
  logic              m_op;
  logic [7:0]        m_din;
  logic              m_busy;
  logic              m_done;
  logic              m_ack_err;
  logic [7:0]        m_dout;
  logic              m_rst;
  modport slave (
    input  req, req_addr, req_op, req_din, m_busy, m_done, m_ack_err, m_dout,
    output gnt, rsp_valid, rsp_data, rsp_err, rsp_timeout, arb_busy, m_newd, m_addr, m_op, m_din, m_rst
  );
  modport master (
    output req, req_addr, req_op, req_din, m_busy, m_done, m_ack_err, m_dout,
    input  gnt, rsp_valid, rsp_data, rsp_err, rsp_timeout, arb_busy, m_newd, m_addr, m_op, m_din, m_rst
  );
endinterface

// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: round-robin share of one i2c_master among NREQ requesters with watchdog abort; ports clk, rst (sync active-high), bus (slave modport: requester req/gnt/rsp_* and master m_* handshake)
module i2c_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16384
) (
  input logic              clk,
  input logic              rst,
  i2c_req_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;
  state_t          r_state;
  logic [PW-1:0]   r_ptr, r_win, w_win, w_k, w_next;
  logic [TW-1:0]   r_timer;
  logic [NREQ-1:0] r_gnt, r_rsp_valid;
  logic [7:0]      r_rsp_data, r_din;
  logic [6:0]      r_addr;
  logic            r_rsp_err, r_rsp_timeout, r_busy, r_newd, r_op, r_abort;
  logic            w_done, w_expire;
  always_comb begin
    w_win = r_ptr;
    w_k   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_k = PW'((int'(r_ptr) + i) % NREQ);
      if (bus.req[w_k]) w_win = w_k;
    end
  end
  assign w_next   = (r_win == PW'(NREQ - 1)) ? '0 : r_win + 1'b1;
  assign w_done   = (r_state == WAIT_DONE) && bus.m_done;
  assign w_expire = (r_state != IDLE) && (r_timer == TW'(TIMEOUT - 1)) && !w_done;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_win         <= '0;
      r_timer       <= '0;
      r_gnt         <= '0;
      r_rsp_valid   <= '0;
      r_rsp_data    <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_busy        <= 1'b0;
      r_newd        <= 1'b0;
      r_addr        <= '0;
      r_op          <= 1'b0;
      r_din         <= '0;
      r_abort       <= 1'b0;
    end else begin
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_abort     <= 1'b0;
      if (r_state == IDLE) begin
        r_busy <= |bus.req;
        if (|bus.req) begin
          r_win   <= w_win;
          r_addr  <= bus.req_addr[7*w_win +: 7];
          r_op    <= bus.req_op[w_win];
          r_din   <= bus.req_din[8*w_win +: 8];
          r_gnt   <= NREQ'(1) << w_win;
          r_newd  <= 1'b1;
          r_timer <= '0;
          r_state <= ISSUE;
        end
      end else begin
        r_timer <= r_timer + 1'b1;
        if (r_state == ISSUE && bus.m_busy) begin
          r_newd  <= 1'b0;
          r_state <= WAIT_DONE;
        end
        if (w_done || w_expire) begin
          r_rsp_data    <= w_done ? bus.m_dout : 8'h00;
          r_rsp_err     <= w_done ? bus.m_ack_err : 1'b1;
          r_rsp_timeout <= !w_done;
          r_abort       <= !w_done;
          r_newd        <= 1'b0;
          r_rsp_valid   <= NREQ'(1) << r_win;
          r_ptr         <= w_next;
          r_state       <= IDLE;
        end
      end
    end
  end
  assign bus.gnt         = r_gnt;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_data    = r_rsp_data;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_timeout = r_rsp_timeout;
  assign bus.arb_busy    = r_busy;
  assign bus.m_newd      = r_newd;
  assign bus.m_addr      = r_addr;
  assign bus.m_op        = r_op;
  assign bus.m_din       = r_din;
  assign bus.m_rst       = rst | r_abort;
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb_i2c_req_arbiter: scoreboard bench for i2c_req_arbiter with a behavioural i2c_master stub
module tb_i2c_req_arbiter;
  localparam int NREQ = 4;
  localparam int TO   = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  i2c_req_arbiter_if #(.NREQ(NREQ)) bus();
  i2c_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    int         idx;
    logic [7:0] data;
    logic       err;
    logic       to;
  } exp_t;
  exp_t sb[$];
  int   gnt_log[$];
  int   gap_log[$];
  int   n_chk = 0, n_pass = 0, cyc = 0, last_rsp = 0, abort_cyc = 0, outst = 0, ovl = 0;
  logic s_busy = 1'b0, hang = 1'b0;
  int   s_cnt = 0, dur = 8;
  logic [7:0] cap_byte = 8'h00, cap_din = 8'h00;
  always @(posedge clk) cyc <= cyc + 1;
  // master stub: busy the edge after newd, done after dur cycles; address 0x12 NACKs, reads return 0x3C
  always @(posedge clk) begin
    bus.m_done <= 1'b0;
    if (bus.m_rst) begin
      s_busy     <= 1'b0;
      bus.m_busy <= 1'b0;
    end else if (!s_busy && bus.m_newd) begin
      s_busy     <= 1'b1;
      bus.m_busy <= 1'b1;
      s_cnt      <= dur;
      cap_byte   <= {bus.m_addr, bus.m_op};
      cap_din    <= bus.m_din;
    end else if (s_busy && !hang) begin
      if (s_cnt == 0) begin
        s_busy        <= 1'b0;
        bus.m_busy    <= 1'b0;
        bus.m_done    <= 1'b1;
        bus.m_dout    <= cap_byte[0] ? 8'h3C : 8'h00;
        bus.m_ack_err <= (cap_byte[7:1] == 7'h12);
      end else s_cnt <= s_cnt - 1;
    end
  end
  function automatic int idx_of(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction
  // monitor: grant log, overlap tracking, scoreboard pop on every response
  always @(negedge clk) begin
    exp_t e;
    logic [NREQ-1:0] want;
    if (rst) outst = 0;
    if (!rst && bus.m_rst) abort_cyc = cyc;
    if (bus.rsp_valid != 0) begin
      last_rsp = cyc;
      outst = outst - 1;
      n_chk++;
      if (sb.size() == 0) $display("FAIL unexpected_rsp: rsp_valid=%b with nothing expected", bus.rsp_valid);
      else begin
        e = sb.pop_front();
        want = NREQ'(1) << e.idx;
        if (bus.rsp_valid !== want || bus.rsp_data !== e.data || bus.rsp_err !== e.err || bus.rsp_timeout !== e.to)
          $display("FAIL rsp: got valid=%b data=%h err=%b to=%b, want valid=%b data=%h err=%b to=%b",
                   bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.rsp_timeout, want, e.data, e.err, e.to);
        else n_pass++;
      end
    end
    if (bus.gnt != 0) begin
      gnt_log.push_back(idx_of(bus.gnt));
      gap_log.push_back(cyc - last_rsp);
      if (!$onehot(bus.gnt) || outst != 0) ovl++;
      outst = outst + 1;
    end
  end
  task automatic set_req(input int i, input logic [6:0] a, input logic op, input logic [7:0] d);
    bus.req_addr[7*i +: 7] = a;
    bus.req_op[i]          = op;
    bus.req_din[8*i +: 8]  = d;
  endtask
  task automatic wait_gnt(output logic [NREQ-1:0] g, output int gc);
    g  = '0;
    gc = 0;
    for (int k = 0; k < 100 && g == 0; k++) begin
      @(negedge clk);
      g  = bus.gnt;
      gc = cyc;
    end
  endtask
  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      ok = (sb.size() == 0);
    end
  endtask
  task automatic test_reset;
    rst          = 1'b1;
    bus.req      = '0;
    bus.req_addr = '0;
    bus.req_op   = '0;
    bus.req_din  = '0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({bus.gnt, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.rsp_timeout, bus.arb_busy, bus.m_newd,
         bus.m_addr, bus.m_op, bus.m_din, bus.m_rst} !== 37'd1)
      $display("FAIL reset_outputs: got gnt=%b rv=%b data=%h err=%b to=%b busy=%b newd=%b addr=%h op=%b din=%h mrst=%b, want all 0 and mrst=1",
               bus.gnt, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.rsp_timeout, bus.arb_busy, bus.m_newd,
               bus.m_addr, bus.m_op, bus.m_din, bus.m_rst);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.m_rst !== 1'b0) $display("FAIL m_rst_release: got %b want 0", bus.m_rst);
    else n_pass++;
  endtask
  task automatic test_write;
    bit ok;
    set_req(0, 7'h50, 1'b0, 8'hA5);
    sb.push_back('{0, 8'h00, 1'b0, 1'b0});
    bus.req = 4'b0001;
    @(negedge clk);
    n_chk++;
    if (bus.gnt !== 4'b0001) $display("FAIL write_gnt_t1: got %b want 0001", bus.gnt);
    else n_pass++;
    n_chk++;
    if (bus.m_newd !== 1'b1) $display("FAIL write_newd_t1: got %b want 1", bus.m_newd);
    else n_pass++;
    bus.req = '0;
    @(negedge clk);
    n_chk++;
    if ({bus.gnt, bus.m_newd} !== 5'b0000_1) $display("FAIL write_t2: got gnt=%b newd=%b want 0000 1", bus.gnt, bus.m_newd);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (bus.m_newd !== 1'b0) $display("FAIL write_newd_t3: got %b want 0", bus.m_newd);
    else n_pass++;
    wait_drain(ok);
    n_chk++;
    if (!ok) $display("FAIL write_drain: got %0d pending want 0", sb.size());
    else n_pass++;
    n_chk++;
    if ({cap_byte, cap_din} !== 16'hA0A5) $display("FAIL write_bytes: got %h %h want a0 a5", cap_byte, cap_din);
    else n_pass++;
  endtask
  task automatic test_fairness;
    bit ok;
    int order[6] = '{0, 1, 3, 0, 1, 3};
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    gnt_log.delete();
    gap_log.delete();
    ovl = 0;
    for (int i = 0; i < NREQ; i++) set_req(i, 7'(7'h40 + i), 1'b0, 8'(8'h10 + i));
    for (int k = 0; k < 6; k++) sb.push_back('{order[k], 8'h00, 1'b0, 1'b0});
    bus.req = 4'b1011;
    for (int k = 0; k < 400 && gnt_log.size() < 6; k++) @(negedge clk);
    bus.req = '0;
    wait_drain(ok);
    n_chk++;
    if (!ok || gnt_log.size() != 6) $display("FAIL fair_count: got %0d grants want 6", gnt_log.size());
    else n_pass++;
    for (int k = 0; k < 6 && k < gnt_log.size(); k++) begin
      n_chk++;
      if (gnt_log[k] !== order[k]) $display("FAIL fair_order[%0d]: got %0d want %0d", k, gnt_log[k], order[k]);
      else n_pass++;
    end
    for (int k = 1; k < 6 && k < gap_log.size(); k++) begin
      n_chk++;
      if (gap_log[k] !== 1) $display("FAIL back_to_back[%0d]: got gap %0d want 1", k, gap_log[k]);
      else n_pass++;
    end
    n_chk++;
    if (ovl !== 0) $display("FAIL fair_overlap: got %0d want 0", ovl);
    else n_pass++;
  endtask
  task automatic test_read;
    bit ok;
    logic [NREQ-1:0] g;
    int gc;
    set_req(2, 7'h51, 1'b1, 8'h00);
    sb.push_back('{2, 8'h3C, 1'b0, 1'b0});
    bus.req = 4'b0100;
    wait_gnt(g, gc);
    bus.req = '0;
    n_chk++;
    if (g !== 4'b0100) $display("FAIL read_gnt: got %b want 0100", g);
    else n_pass++;
    wait_drain(ok);
    n_chk++;
    if (!ok || cap_byte !== 8'hA3) $display("FAIL read_addr_byte: got %h ok=%0d want a3", cap_byte, ok);
    else n_pass++;
  endtask
  task automatic test_nack;
    bit ok;
    logic [NREQ-1:0] g;
    int gc;
    set_req(1, 7'h12, 1'b0, 8'h77);
    sb.push_back('{1, 8'h00, 1'b1, 1'b0});
    bus.req = 4'b0010;
    wait_gnt(g, gc);
    bus.req = '0;
    n_chk++;
    if (g !== 4'b0010) $display("FAIL nack_gnt: got %b want 0010", g);
    else n_pass++;
    wait_drain(ok);
    set_req(0, 7'h21, 1'b0, 8'h01);
    set_req(1, 7'h22, 1'b0, 8'h02);
    set_req(2, 7'h51, 1'b1, 8'h00);
    sb.push_back('{2, 8'h3C, 1'b0, 1'b0});
    bus.req = 4'b0111;
    wait_gnt(g, gc);
    bus.req = '0;
    n_chk++;
    if (g !== 4'b0100) $display("FAIL nack_ptr_advance: got %b want 0100", g);
    else n_pass++;
    wait_drain(ok);
    n_chk++;
    if (!ok) $display("FAIL nack_drain: got %0d pending want 0", sb.size());
    else n_pass++;
  endtask
  task automatic test_timeout;
    bit ok;
    logic [NREQ-1:0] g;
    int gc;
    hang      = 1'b1;
    abort_cyc = 0;
    set_req(3, 7'h33, 1'b0, 8'h5A);
    sb.push_back('{3, 8'h00, 1'b1, 1'b1});
    bus.req = 4'b1000;
    wait_gnt(g, gc);
    bus.req = '0;
    n_chk++;
    if (g !== 4'b1000) $display("FAIL to_gnt: got %b want 1000", g);
    else n_pass++;
    wait_drain(ok);
    n_chk++;
    if (!ok || abort_cyc - gc !== TO) $display("FAIL to_delay: got %0d cycles want %0d", abort_cyc - gc, TO);
    else n_pass++;
    n_chk++;
    if (last_rsp !== abort_cyc) $display("FAIL to_same_cycle: got rsp at %0d abort at %0d want equal", last_rsp, abort_cyc);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({bus.m_rst, bus.arb_busy} !== 2'b00) $display("FAIL to_after: got mrst=%b busy=%b want 0 0", bus.m_rst, bus.arb_busy);
    else n_pass++;
    hang = 1'b0;
  endtask
  task automatic test_reset_mid;
    bit ok;
    logic [NREQ-1:0] g;
    int gc;
    dur = 30;
    set_req(2, 7'h51, 1'b0, 8'h99);
    bus.req = 4'b0100;
    wait_gnt(g, gc);
    bus.req = '0;
    n_chk++;
    if (g !== 4'b0100) $display("FAIL rstmid_gnt: got %b want 0100", g);
    else n_pass++;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({bus.gnt, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.rsp_timeout, bus.arb_busy, bus.m_newd,
         bus.m_addr, bus.m_op, bus.m_din, bus.m_rst} !== 37'd1)
      $display("FAIL rstmid_outputs: got rv=%b data=%h err=%b to=%b busy=%b newd=%b addr=%h din=%h mrst=%b, want all 0 and mrst=1",
               bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.rsp_timeout, bus.arb_busy, bus.m_newd,
               bus.m_addr, bus.m_din, bus.m_rst);
    else n_pass++;
    rst = 1'b0;
    dur = 8;
    set_req(1, 7'h20, 1'b0, 8'h11);
    set_req(2, 7'h24, 1'b0, 8'h22);
    sb.push_back('{1, 8'h00, 1'b0, 1'b0});
    bus.req = 4'b0110;
    wait_gnt(g, gc);
    bus.req = '0;
    n_chk++;
    if (g !== 4'b0010) $display("FAIL rstmid_next_gnt: got %b want 0010", g);
    else n_pass++;
    wait_drain(ok);
    n_chk++;
    if (!ok) $display("FAIL rstmid_drain: got %0d pending want 0", sb.size());
    else n_pass++;
    repeat (40) @(negedge clk);
  endtask
  initial begin
    test_reset();
    test_write();
    test_fairness();
    test_read();
    test_nack();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete within 200000 time units");
    $fatal(1);
  end
endmodule
